mem_access: RTL and testbench

//  MEM stage; sits directly downstream of execute and consumes its EX_MEM_* bundle.
//  - Loads/stores: drives the AHB-lite data port (address phase, then data phase).
//  - Loads: byte-lane extraction and sign/zero extension.
//  - Produces the registered MEM_WB_* bundle for writeback and forwarding.
//  - Stalls upstream while a transfer is outstanding.

---
 rtl/mem_access.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage driving an AHB-lite data port and producing the MEM_WB bundle.
// Optional macro MISALIGN_TRAP_EN traps misaligned halfword/word accesses instead of aligning them.
module mem_access #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] EX_MEM_pc,
    input  logic [31:0] EX_MEM_inst,
    input  logic [31:0] EX_MEM_alu,
    input  logic [31:0] EX_MEM_rs2,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_is_load,
    input  logic        EX_MEM_is_store,
    output logic [31:0] HADDR_D,
    output logic [1:0]  HTRANS_D,
    output logic        HWRITE_D,
    output logic [2:0]  HSIZE_D,
    output logic [31:0] HWDATA_D,
    input  logic [31:0] HRDATA_D,
    input  logic        HREADY_D,
    input  logic        HRESP_D,
    output logic [31:0] MEM_WB_pc,
    output logic [31:0] MEM_WB_inst,
    output logic [4:0]  MEM_WB_rd,
    output logic [31:0] MEM_WB_wdata,
    output logic        MEM_WB_we,
    output logic        mem_stall,
    output logic        mem_err
);

    localparam logic [9:0] TO_LAST   = 10'(TIMEOUT_CYC - 1);
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    typedef enum logic {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_t;

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b0010011, 7'b0110011, 7'b0000011: writes_rd = 1'b1;
            default:                            writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] lo,
                                                 input logic [2:0] f3);
        logic [31:0] lane;
        lane = rdata >> {lo, 3'b000};
        case (f3)
            3'b000:  load_extract = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_extract = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_extract = {24'd0, lane[7:0]};
            3'b101:  load_extract = {16'd0, lane[15:0]};
            default: load_extract = lane;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] d, input logic [1:0] sz);
        case (sz)
            2'b00:   store_lanes = {4{d[7:0]}};
            2'b01:   store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [31:0] inst_q, inst_d, pc_q, pc_d, alu_q, alu_d, rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  f3_q, f3_d;
    logic        ld_q, ld_d;
    logic [9:0]  wcnt_q, wcnt_d;
    logic [31:0] wb_pc_q, wb_pc_d, wb_inst_q, wb_inst_d, wb_wdata_q, wb_wdata_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_we_q, wb_we_d, err_q, err_d;
    logic        access_s, trap_s, issue_s, timeout_s;
    logic [31:0] addr_s;

    // Access decode: alignment handling and the abort condition for a stuck data phase
    always_comb begin
        access_s = (EX_MEM_is_load | EX_MEM_is_store) && (EX_MEM_inst != 32'd0);
`ifdef MISALIGN_TRAP_EN
        addr_s = EX_MEM_alu;
        case (EX_MEM_inst[13:12])
            2'b01:   trap_s = access_s & EX_MEM_alu[0];
            2'b10:   trap_s = access_s & (EX_MEM_alu[1:0] != 2'b00);
            default: trap_s = 1'b0;
        endcase
`else
        trap_s = 1'b0;
        case (EX_MEM_inst[13:12])
            2'b01:   addr_s = {EX_MEM_alu[31:1], 1'b0};
            2'b10:   addr_s = {EX_MEM_alu[31:2], 2'b00};
            default: addr_s = EX_MEM_alu;
        endcase
`endif
        issue_s   = (state_q == ST_IDLE) && access_s && !trap_s;
        timeout_s = (state_q == ST_DATA) && !HREADY_D && (wcnt_q >= TO_LAST);
    end

    // Bus and stall outputs; forced idle while reset is held so a live transfer is dropped at once
    always_comb begin
        HTRANS_D  = HT_IDLE;
        HADDR_D   = 32'd0;
        HWRITE_D  = 1'b0;
        HSIZE_D   = 3'b000;
        HWDATA_D  = 32'd0;
        mem_stall = 1'b0;
        if (RES) begin
            mem_stall = 1'b0;
        end else if (state_q == ST_DATA) begin
            HWDATA_D  = store_lanes(rs2_q, f3_q[1:0]);
            mem_stall = !HREADY_D && !timeout_s;
        end else if (issue_s) begin
            HTRANS_D  = HT_NONSEQ;
            HADDR_D   = addr_s;
            HWRITE_D  = EX_MEM_is_store;
            HSIZE_D   = {1'b0, EX_MEM_inst[13:12]};
            mem_stall = 1'b1;
        end else begin
            mem_stall = 1'b0;
        end
    end

    // Next-state: transfer sequencing, wait counting and the retire bundle
    always_comb begin
        state_d = state_q;
        inst_d = inst_q; pc_d = pc_q; alu_d = alu_q; rs2_d = rs2_q;
        rd_d = rd_q; f3_d = f3_q; ld_d = ld_q; wcnt_d = wcnt_q;
        wb_pc_d = wb_pc_q; wb_rd_d = wb_rd_q; wb_wdata_d = wb_wdata_q;
        wb_inst_d = 32'd0;
        wb_we_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_s) begin
                    if (HREADY_D) begin
                        inst_d = EX_MEM_inst; pc_d = EX_MEM_pc; alu_d = addr_s;
                        rs2_d = EX_MEM_rs2; rd_d = EX_MEM_rd; f3_d = EX_MEM_inst[14:12];
                        ld_d = EX_MEM_is_load; wcnt_d = 10'd0;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (trap_s) begin
                    err_d = 1'b1;
                end else begin
                    wb_pc_d   = EX_MEM_pc;
                    wb_inst_d = EX_MEM_inst;
                    wb_rd_d   = EX_MEM_rd;
                    wb_we_d   = (EX_MEM_rd != 5'd0) && writes_rd(EX_MEM_inst[6:0]);
                    if (EX_MEM_inst[6:0] == 7'b1101111 || EX_MEM_inst[6:0] == 7'b1100111) begin
                        wb_wdata_d = EX_MEM_pc + 32'd4;
                    end else begin
                        wb_wdata_d = EX_MEM_alu;
                    end
                end
            end
            ST_DATA: begin
                if (HREADY_D) begin
                    wb_pc_d    = pc_q;
                    wb_inst_d  = inst_q;
                    wb_rd_d    = rd_q;
                    wb_wdata_d = ld_q ? load_extract(HRDATA_D, alu_q[1:0], f3_q) : alu_q;
                    wb_we_d    = !HRESP_D && (rd_q != 5'd0) && writes_rd(inst_q[6:0]);
                    err_d      = HRESP_D;
                    wcnt_d     = 10'd0;
                    state_d    = ST_IDLE;
                end else if (timeout_s) begin
                    wb_pc_d   = pc_q;
                    wb_inst_d = inst_q;
                    wb_rd_d   = rd_q;
                    err_d     = 1'b1;
                    wcnt_d    = 10'd0;
                    state_d   = ST_IDLE;
                end else begin
                    wcnt_d = (wcnt_q == 10'h3FF) ? wcnt_q : wcnt_q + 10'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q <= ST_IDLE;
            inst_q <= 32'd0; pc_q <= 32'd0; alu_q <= 32'd0; rs2_q <= 32'd0;
            rd_q <= 5'd0; f3_q <= 3'd0; ld_q <= 1'b0; wcnt_q <= 10'd0;
            wb_pc_q <= 32'd0; wb_inst_q <= 32'd0; wb_wdata_q <= 32'd0;
            wb_rd_q <= 5'd0; wb_we_q <= 1'b0; err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q <= inst_d; pc_q <= pc_d; alu_q <= alu_d; rs2_q <= rs2_d;
            rd_q <= rd_d; f3_q <= f3_d; ld_q <= ld_d; wcnt_q <= wcnt_d;
            wb_pc_q <= wb_pc_d; wb_inst_q <= wb_inst_d; wb_wdata_q <= wb_wdata_d;
            wb_rd_q <= wb_rd_d; wb_we_q <= wb_we_d; err_q <= err_d;
        end
    end

    assign MEM_WB_pc    = wb_pc_q;
    assign MEM_WB_inst  = wb_inst_q;
    assign MEM_WB_rd    = wb_rd_q;
    assign MEM_WB_wdata = wb_wdata_q;
    assign MEM_WB_we    = wb_we_q;
    assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (TIMEOUT_CYC = 4); honours MISALIGN_TRAP_EN when defined.
module tb_mem_access;

    logic        CLK = 1'b0, RES = 1'b1;
    logic [31:0] EX_MEM_pc, EX_MEM_inst, EX_MEM_alu, EX_MEM_rs2;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_is_load, EX_MEM_is_store;
    logic [31:0] HADDR_D, HWDATA_D, HRDATA_D;
    logic [1:0]  HTRANS_D;
    logic        HWRITE_D, HREADY_D, HRESP_D;
    logic [2:0]  HSIZE_D;
    logic [31:0] MEM_WB_pc, MEM_WB_inst, MEM_WB_wdata;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_we, mem_stall, mem_err;

    int n_cmp = 0, n_err = 0, n_stall, n_ret;
    logic [31:0] ap_haddr, dp_hwdata;
    logic [1:0]  ap_htrans;
    logic        ap_hwrite;
    logic [2:0]  ap_hsize;

    localparam logic [31:0] I_LW   = 32'h0000_A283; // lw  x5
    localparam logic [31:0] I_LB   = 32'h0000_8303; // lb  x6
    localparam logic [31:0] I_LBU  = 32'h0000_C383; // lbu x7
    localparam logic [31:0] I_LH   = 32'h0000_9403; // lh  x8
    localparam logic [31:0] I_SH   = 32'h0000_9023; // sh
    localparam logic [31:0] I_ADDI = 32'h0000_8213; // addi x4
    localparam logic [31:0] I_JAL  = 32'h0000_00EF; // jal x1

    mem_access #(.TIMEOUT_CYC(4)) dut (
        .CLK(CLK), .RES(RES),
        .EX_MEM_pc(EX_MEM_pc), .EX_MEM_inst(EX_MEM_inst), .EX_MEM_alu(EX_MEM_alu),
        .EX_MEM_rs2(EX_MEM_rs2), .EX_MEM_rd(EX_MEM_rd),
        .EX_MEM_is_load(EX_MEM_is_load), .EX_MEM_is_store(EX_MEM_is_store),
        .HADDR_D(HADDR_D), .HTRANS_D(HTRANS_D), .HWRITE_D(HWRITE_D), .HSIZE_D(HSIZE_D),
        .HWDATA_D(HWDATA_D), .HRDATA_D(HRDATA_D), .HREADY_D(HREADY_D), .HRESP_D(HRESP_D),
        .MEM_WB_pc(MEM_WB_pc), .MEM_WB_inst(MEM_WB_inst), .MEM_WB_rd(MEM_WB_rd),
        .MEM_WB_wdata(MEM_WB_wdata), .MEM_WB_we(MEM_WB_we),
        .mem_stall(mem_stall), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] pc, inst, alu, rs2, input logic [4:0] rd,
                          input logic ld, st);
        EX_MEM_pc = pc; EX_MEM_inst = inst; EX_MEM_alu = alu; EX_MEM_rs2 = rs2;
        EX_MEM_rd = rd; EX_MEM_is_load = ld; EX_MEM_is_store = st;
    endtask

    // One memory op: address phase, 'waits' stalled data cycles, then the completing data cycle
    task automatic mem_op(input logic [31:0] inst, alu, rs2, input logic [4:0] rd,
                          input logic ld, st, input logic [31:0] rdata, input logic resp,
                          input int waits);
        set_ex(32'h0000_0300, inst, alu, rs2, rd, ld, st);
        HREADY_D = 1'b1; HRESP_D = 1'b0; n_stall = 0; n_ret = 0;
        #1;
        ap_htrans = HTRANS_D; ap_haddr = HADDR_D; ap_hwrite = HWRITE_D; ap_hsize = HSIZE_D;
        n_stall += int'(mem_stall);
        tick();
        n_ret += int'(MEM_WB_inst != 32'd0);
        for (int i = 0; i < waits; i++) begin
            HREADY_D = 1'b0;
            #1 n_stall += int'(mem_stall);
            tick();
            n_ret += int'(MEM_WB_inst != 32'd0);
        end
        HREADY_D = 1'b1; HRDATA_D = rdata; HRESP_D = resp;
        #1;
        dp_hwdata = HWDATA_D;
        n_stall += int'(mem_stall);
        tick();
        n_ret += int'(MEM_WB_inst != 32'd0);
        set_ex(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        HRESP_D = 1'b0; HRDATA_D = 32'd0;
    endtask

    initial begin
        set_ex(32'h0, I_LW, 32'h100, 32'h0, 5'd5, 1'b1, 1'b0);
        HRDATA_D = 32'd0; HREADY_D = 1'b1; HRESP_D = 1'b0;
        tick(); tick();
        // reset: a pending load must not reach the bus
        chk("rst_htrans", 32'(HTRANS_D), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_we", 32'(MEM_WB_we), 32'd0);
        chk("rst_inst", MEM_WB_inst, 32'd0);
        chk("rst_wdata", MEM_WB_wdata, 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        set_ex(32'h10, I_ADDI, 32'h55, 32'h0, 5'd4, 1'b0, 1'b0);
        RES = 1'b0;
        #1;
        chk("alu_htrans", 32'(HTRANS_D), 32'd0);
        chk("alu_stall", 32'(mem_stall), 32'd0);
        tick();
        chk("alu_wdata", MEM_WB_wdata, 32'h55);
        chk("alu_we", 32'(MEM_WB_we), 32'd1);
        chk("alu_rd", 32'(MEM_WB_rd), 32'd4);
        chk("alu_pc", MEM_WB_pc, 32'h10);
        set_ex(32'h200, I_JAL, 32'hDEAD, 32'h0, 5'd1, 1'b0, 1'b0);
        tick();
        chk("jal_wdata", MEM_WB_wdata, 32'h204);
        chk("jal_we", 32'(MEM_WB_we), 32'd1);
        set_ex(32'h204, 32'h0000_8013, 32'h7, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("x0_we", 32'(MEM_WB_we), 32'd0);
        set_ex(32'h208, 32'd0, 32'h100, 32'h0, 5'd5, 1'b1, 1'b0);
        #1 chk("bub_htrans", 32'(HTRANS_D), 32'd0);
        tick();
        chk("bub_inst", MEM_WB_inst, 32'd0);
        chk("bub_we", 32'(MEM_WB_we), 32'd0);

        mem_op(I_LW, 32'h100, 32'h0, 5'd5, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 0);
        chk("lw_htrans", 32'(ap_htrans), 32'd2);
        chk("lw_haddr", ap_haddr, 32'h100);
        chk("lw_hwrite", 32'(ap_hwrite), 32'd0);
        chk("lw_hsize", 32'(ap_hsize), 32'd2);
        chk("lw_stalls", 32'(n_stall), 32'd1);
        chk("lw_retires", 32'(n_ret), 32'd1);
        chk("lw_wdata", MEM_WB_wdata, 32'hDEADBEEF);
        chk("lw_we", 32'(MEM_WB_we), 32'd1);
        chk("lw_rd", 32'(MEM_WB_rd), 32'd5);
        chk("lw_pc", MEM_WB_pc, 32'h300);
        chk("lw_inst", MEM_WB_inst, I_LW);

        mem_op(I_LB, 32'h103, 32'h0, 5'd6, 1'b1, 1'b0, 32'h80FF_0000, 1'b0, 0);
        chk("lb_haddr", ap_haddr, 32'h103);
        chk("lb_wdata", MEM_WB_wdata, 32'hFFFF_FF80);
        mem_op(I_LBU, 32'h103, 32'h0, 5'd7, 1'b1, 1'b0, 32'h80FF_0000, 1'b0, 0);
        chk("lbu_wdata", MEM_WB_wdata, 32'h0000_0080);
        mem_op(I_LH, 32'h102, 32'h0, 5'd8, 1'b1, 1'b0, 32'h80FF_0000, 1'b0, 0);
        chk("lh_wdata", MEM_WB_wdata, 32'hFFFF_80FF);

        mem_op(I_SH, 32'h102, 32'h1234_ABCD, 5'd3, 1'b0, 1'b1, 32'h0, 1'b0, 0);
        chk("sh_hsize", 32'(ap_hsize), 32'd1);
        chk("sh_hwrite", 32'(ap_hwrite), 32'd1);
        chk("sh_haddr", ap_haddr, 32'h102);
        chk("sh_hwdata", dp_hwdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(MEM_WB_we), 32'd0);

        mem_op(I_LW, 32'h104, 32'h0, 5'd5, 1'b1, 1'b0, 32'h1122_3344, 1'b0, 3);
        chk("wait_stalls", 32'(n_stall), 32'd4);
        chk("wait_retires", 32'(n_ret), 32'd1);
        chk("wait_wdata", MEM_WB_wdata, 32'h1122_3344);
        chk("wait_err", 32'(mem_err), 32'd0);

        // timeout: HREADY_D held low, abort on the 4th wait cycle
        set_ex(32'h400, I_LW, 32'h108, 32'h0, 5'd5, 1'b1, 1'b0);
        HREADY_D = 1'b1;
        tick();
        HREADY_D = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1 chk($sformatf("to_stall%0d", i), 32'(mem_stall), 32'd1);
            tick();
            chk($sformatf("to_noerr%0d", i), 32'(mem_err), 32'd0);
        end
        #1 chk("to_stall4", 32'(mem_stall), 32'd0);
        tick();
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_we", 32'(MEM_WB_we), 32'd0);
        chk("to_inst", MEM_WB_inst, I_LW);
        set_ex(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        HREADY_D = 1'b1;
        tick();
        chk("to_pulse", 32'(mem_err), 32'd0);

        mem_op(I_LW, 32'h10C, 32'h0, 5'd5, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1, 0);
        chk("resp_err", 32'(mem_err), 32'd1);
        chk("resp_we", 32'(MEM_WB_we), 32'd0);
        tick();
        chk("resp_pulse", 32'(mem_err), 32'd0);

        // reset asserted in the middle of a data phase
        set_ex(32'h500, I_LW, 32'h110, 32'h0, 5'd5, 1'b1, 1'b0);
        HREADY_D = 1'b1;
        tick();
        HREADY_D = 1'b0;
        #1 chk("rd_stall", 32'(mem_stall), 32'd1);
        RES = 1'b1;
        #1;
        chk("ra_htrans", 32'(HTRANS_D), 32'd0);
        chk("ra_haddr", HADDR_D, 32'd0);
        chk("ra_stall", 32'(mem_stall), 32'd0);
        chk("ra_wdata", MEM_WB_wdata, 32'd0);
        chk("ra_pc", MEM_WB_pc, 32'd0);
        tick();
        RES = 1'b0;
        mem_op(I_LW, 32'h114, 32'h0, 5'd5, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, 0);
        chk("rec_wdata", MEM_WB_wdata, 32'h0BAD_F00D);

`ifdef MISALIGN_TRAP_EN
        set_ex(32'h600, I_LW, 32'h102, 32'h0, 5'd5, 1'b1, 1'b0);
        HREADY_D = 1'b1;
        #1;
        chk("mis_htrans", 32'(HTRANS_D), 32'd0);
        chk("mis_stall", 32'(mem_stall), 32'd0);
        tick();
        chk("mis_err", 32'(mem_err), 32'd1);
        chk("mis_inst", MEM_WB_inst, 32'd0);
        chk("mis_we", 32'(MEM_WB_we), 32'd0);
        set_ex(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("mis_pulse", 32'(mem_err), 32'd0);
`else
        mem_op(I_LW, 32'h102, 32'h0, 5'd5, 1'b1, 1'b0, 32'h5566_7788, 1'b0, 0);
        chk("mis_haddr", ap_haddr, 32'h100);
        chk("mis_htrans", 32'(ap_htrans), 32'd2);
        chk("mis_wdata", MEM_WB_wdata, 32'h5566_7788);
        chk("mis_err", 32'(mem_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
